// File: rtl/reg_seq_pkg.sv
// Shared definitions for the FunSel register-operation sequencer:
// FunSel command encodings, request opcodes, sequencer states and
// small decode helpers used by the sequencer.
package reg_seq_pkg;

  localparam logic [1:0] FS_DEC  = 2'b00;
  localparam logic [1:0] FS_INC  = 2'b01;
  localparam logic [1:0] FS_LOAD = 2'b10;
  localparam logic [1:0] FS_CLR  = 2'b11;

  typedef enum logic [2:0] {
    OP_DEC   = 3'b000,
    OP_INC   = 3'b001,
    OP_LOAD  = 3'b010,
    OP_CLEAR = 3'b011,
    OP_ADDK  = 3'b100,
    OP_SUBK  = 3'b101,
    OP_COPY  = 3'b110,
    OP_RSVD  = 3'b111
  } req_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WRITE  = 2'b01,
    SAMPLE = 2'b10
  } seq_state_t;

  // Number of register write cycles an operation expands into.
  function automatic logic [7:0] step_count(input req_op_t op, input logic [7:0] count);
    case (op)
      OP_ADDK, OP_SUBK: step_count = count;
      OP_RSVD:          step_count = 8'd0;
      default:          step_count = 8'd1;
    endcase
  endfunction

  // FunSel command issued on every write cycle of an operation.
  function automatic logic [1:0] op_funsel(input req_op_t op);
    case (op)
      OP_DEC:   op_funsel = FS_DEC;
      OP_INC:   op_funsel = FS_INC;
      OP_LOAD:  op_funsel = FS_LOAD;
      OP_CLEAR: op_funsel = FS_CLR;
      OP_ADDK:  op_funsel = FS_INC;
      OP_SUBK:  op_funsel = FS_DEC;
      OP_COPY:  op_funsel = FS_LOAD;
      default:  op_funsel = FS_DEC;
    endcase
  endfunction

endpackage

// File: rtl/reg_op_sequencer.sv
// reg_op_sequencer: command-side master for a bank of NREG FunSel registers.
// Accepts one register operation per valid/ready handshake, expands it into
// per-cycle E/FunSel/I commands, then samples the target Q back and returns
// it with a one-cycle Done pulse.
// Ports:
//   Clock, Reset            - clock, synchronous active-high reset
//   ReqValid/ReqReady       - request handshake (ReqReady high only in IDLE)
//   ReqReg, ReqSrc, ReqOp   - target index, COPY source index, opcode
//   ReqData                 - LOAD value; ADDK/SUBK count in [7:0]
//   QBus                    - {Q[NREG-1],...,Q0} from the register bank
//   E, FunSel, I            - registered register-bank command lines
//   Done, Result, Error     - completion pulse, target Q, reserved-op flag
module reg_op_sequencer
  import reg_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREG  = 4
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    ReqValid,
  output logic                    ReqReady,
  input  logic [1:0]              ReqReg,
  input  logic [1:0]              ReqSrc,
  input  logic [2:0]              ReqOp,
  input  logic [WIDTH-1:0]        ReqData,
  input  logic [NREG*WIDTH-1:0]   QBus,
  output logic [NREG-1:0]         E,
  output logic [1:0]              FunSel,
  output logic [WIDTH-1:0]        I,
  output logic                    Done,
  output logic [WIDTH-1:0]        Result,
  output logic                    Error
);

  seq_state_t       state;
  req_op_t          op_q;
  logic [1:0]       reg_q;
  logic [7:0]       cnt_q;

  req_op_t          req_op;
  logic [7:0]       req_k;
  logic             accept;
  logic [NREG-1:0]  onehot;
  logic [WIDTH-1:0] q [NREG];

  always_comb begin
    for (int unsigned i = 0; i < NREG; i++) begin
      q[i] = QBus[i*WIDTH +: WIDTH];
    end
  end

  assign ReqReady = (state == IDLE);
  assign accept   = ReqValid && ReqReady;
  assign req_op   = req_op_t'(ReqOp);
  assign req_k    = step_count(req_op, ReqData[7:0]);
  assign onehot   = NREG'(1) << ReqReg;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= IDLE;
      op_q   <= OP_DEC;
      reg_q  <= '0;
      cnt_q  <= '0;
      E      <= '0;
      FunSel <= FS_DEC;
      I      <= '0;
      Done   <= 1'b0;
      Result <= '0;
      Error  <= 1'b0;
    end else begin
      Done  <= 1'b0;
      Error <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q  <= req_op;
            reg_q <= ReqReg;
            cnt_q <= req_k;
            // Command lines are loaded at acceptance so the first write
            // cycle is the cycle right after the handshake.
            if (req_k != 8'd0) begin
              state  <= WRITE;
              E      <= onehot;
              FunSel <= op_funsel(req_op);
              if (req_op == OP_LOAD) begin
                I <= ReqData;
              end else if (req_op == OP_COPY) begin
                I <= q[ReqSrc];
              end
            end else begin
              state <= SAMPLE;
            end
          end
        end
        WRITE: begin
          cnt_q <= cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state <= SAMPLE;
            E     <= '0;
          end
        end
        SAMPLE: begin
          Result <= q[reg_q];
          Done   <= 1'b1;
          Error  <= (op_q == OP_RSVD);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Self-checking bench for reg_op_sequencer with a four-register FunSel bank.
module tb_reg_op_sequencer;

  localparam int W = 16;

  logic           Clock = 1'b0;
  logic           Reset = 1'b0;
  logic           ReqValid = 1'b0;
  logic           ReqReady;
  logic [1:0]     ReqReg = '0;
  logic [1:0]     ReqSrc = '0;
  logic [2:0]     ReqOp = '0;
  logic [W-1:0]   ReqData = '0;
  logic [4*W-1:0] QBus;
  logic [3:0]     E;
  logic [1:0]     FunSel;
  logic [W-1:0]   I;
  logic           Done;
  logic [W-1:0]   Result;
  logic           Error;

  int tests = 0;
  int fails = 0;

  always #5 Clock = ~Clock;

  reg_op_sequencer #(.WIDTH(W), .NREG(4)) dut (
    .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqReg(ReqReg), .ReqSrc(ReqSrc), .ReqOp(ReqOp), .ReqData(ReqData),
    .QBus(QBus), .E(E), .FunSel(FunSel), .I(I), .Done(Done),
    .Result(Result), .Error(Error)
  );

  // Four FunSel registers (no reset of their own).
  logic [W-1:0] bank [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
  always @(posedge Clock) begin
    for (int i = 0; i < 4; i++) begin
      if (E[i] === 1'b1) begin
        case (FunSel)
          2'b00:   bank[i] <= bank[i] - 16'd1;
          2'b01:   bank[i] <= bank[i] + 16'd1;
          2'b10:   bank[i] <= I;
          default: bank[i] <= '0;
        endcase
      end
    end
  end
  assign QBus = {bank[3], bank[2], bank[1], bank[0]};

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- transaction-level reference model ----------------
  function automatic int kof(input logic [2:0] op, input logic [15:0] d);
    case (op)
      3'd4, 3'd5: return int'(d[7:0]);
      3'd7:       return 0;
      default:    return 1;
    endcase
  endfunction

  function automatic logic [15:0] apply(input logic [2:0] op, input logic [15:0] qt,
                                        input logic [15:0] qs, input logic [15:0] d);
    case (op)
      3'd0:    return qt - 16'd1;
      3'd1:    return qt + 16'd1;
      3'd2:    return d;
      3'd3:    return 16'h0000;
      3'd4:    return qt + {8'h00, d[7:0]};
      3'd5:    return qt - {8'h00, d[7:0]};
      3'd6:    return qs;
      default: return qt;
    endcase
  endfunction

  function automatic logic [1:0] fsof(input logic [2:0] op);
    case (op)
      3'd1, 3'd4: return 2'b01;
      3'd2, 3'd6: return 2'b10;
      3'd3:       return 2'b11;
      default:    return 2'b00;
    endcase
  endfunction

  int          cyc = 0;
  int          m_acc = 0;
  int          m_k = 0;
  bit          m_active = 1'b0;
  logic [1:0]  m_reg = '0;
  logic [2:0]  m_op = '0;
  logic [15:0] m_base = '0;
  logic [15:0] m_final = '0;
  logic [15:0] m_i = '0;
  logic [15:0] res_hold = '0;
  bit          m_err = 1'b0;
  logic [15:0] mreg [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
  bit          chk_en = 1'b0;

  function automatic bit m_ready();
    return !m_active || ((cyc - m_acc) >= m_k + 2);
  endfunction

  always @(posedge Clock) begin
    cyc <= cyc + 1;
    if (Reset) begin
      // Writes issued before the reset edge (including it) stay applied.
      if (m_active && (cyc - m_acc) < m_k)
        mreg[m_reg] <= (m_op == 3'd4) ? m_base + 16'(cyc - m_acc) : m_base - 16'(cyc - m_acc);
      m_active <= 1'b0;
      res_hold <= '0;
    end else begin
      if (m_active && (cyc - m_acc) == m_k + 1) res_hold <= m_final;
      if (ReqValid && m_ready()) begin
        m_active     <= 1'b1;
        m_acc        <= cyc;
        m_k          <= kof(ReqOp, ReqData);
        m_reg        <= ReqReg;
        m_op         <= ReqOp;
        m_base       <= mreg[ReqReg];
        m_final      <= apply(ReqOp, mreg[ReqReg], mreg[ReqSrc], ReqData);
        mreg[ReqReg] <= apply(ReqOp, mreg[ReqReg], mreg[ReqSrc], ReqData);
        m_i          <= (ReqOp == 3'd2) ? ReqData : mreg[ReqSrc];
        m_err        <= (ReqOp == 3'd7);
      end
    end
  end

  always @(negedge Clock) begin
    int c;
    bit in_wr;
    bit dn;
    logic [3:0] ee;
    if (chk_en) begin
      c     = cyc - m_acc;
      in_wr = m_active && c >= 1 && c <= m_k;
      dn    = m_active && c == m_k + 2;
      ee    = in_wr ? (4'b0001 << m_reg) : 4'b0000;
      chk("ReqReady", {31'd0, ReqReady}, {31'd0, m_ready()});
      chk("E", {28'd0, E}, {28'd0, ee});
      chk("Done", {31'd0, Done}, {31'd0, dn});
      chk("Error", {31'd0, Error}, {31'd0, dn && m_err});
      chk("Result_hold", {16'd0, Result}, {16'd0, res_hold});
      if (in_wr) begin
        chk("FunSel", {30'd0, FunSel}, {30'd0, fsof(m_op)});
        if (m_op == 3'd2 || m_op == 3'd6) chk("I", {16'd0, I}, {16'd0, m_i});
      end
      if (dn) begin
        chk("Result", {16'd0, Result}, {16'd0, m_final});
        for (int i = 0; i < 4; i++) chk("bank", {16'd0, bank[i]}, {16'd0, mreg[i]});
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic start_op(input logic [2:0] op, input logic [1:0] r, input logic [1:0] s,
                          input logic [15:0] d);
    int n;
    n = 0;
    while (ReqReady !== 1'b1 && n < 400) begin
      @(posedge Clock); #1;
      n++;
    end
    chk("ready_wait", {31'd0, ReqReady}, 32'd1);
    ReqOp = op; ReqReg = r; ReqSrc = s; ReqData = d; ReqValid = 1'b1;
    @(posedge Clock); #1;
    ReqValid = 1'b0;
  endtask

  task automatic wait_done(output logic [15:0] res, output logic err,
                           output int ecnt, output int steps);
    ecnt = 0;
    steps = 0;
    while (Done !== 1'b1 && steps < 400) begin
      if (E != 4'b0000) ecnt++;
      @(posedge Clock); #1;
      steps++;
    end
    chk("done_wait", {31'd0, Done}, 32'd1);
    res = Result;
    err = Error;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] res;
    logic        err;
    int          ec;
    int          st;
    logic [2:0]  rop;
    logic [15:0] rd;

    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0;
    chk("rst_E", {28'd0, E}, 32'd0);
    chk("rst_FunSel", {30'd0, FunSel}, 32'd0);
    chk("rst_I", {16'd0, I}, 32'd0);
    chk("rst_ReqReady", {31'd0, ReqReady}, 32'd1);
    chk("rst_Done", {31'd0, Done}, 32'd0);
    chk("rst_Result", {16'd0, Result}, 32'd0);
    chk("rst_Error", {31'd0, Error}, 32'd0);
    chk_en = 1'b1;

    // LOAD R2
    start_op(3'd2, 2'd2, 2'd0, 16'h1234);
    chk("load_E", {28'd0, E}, 32'h4);
    chk("load_FunSel", {30'd0, FunSel}, 32'h2);
    wait_done(res, err, ec, st);
    chk("load_result", {16'd0, res}, 32'h1234);
    chk("load_ecycles", ec, 1);
    chk("load_latency", st, 2);
    chk("load_R0", {16'd0, bank[0]}, 32'h1111);
    chk("load_R1", {16'd0, bank[1]}, 32'h2222);
    chk("load_R3", {16'd0, bank[3]}, 32'h4444);

    // INC/DEC wrap
    start_op(3'd2, 2'd0, 2'd0, 16'hFFFF); wait_done(res, err, ec, st);
    start_op(3'd1, 2'd0, 2'd0, 16'h0000); wait_done(res, err, ec, st);
    chk("inc_wrap", {16'd0, res}, 32'h0000);
    start_op(3'd0, 2'd0, 2'd0, 16'h0000); wait_done(res, err, ec, st);
    chk("dec_wrap", {16'd0, res}, 32'hFFFF);

    // ADDK 200 from 0xFFF0
    start_op(3'd2, 2'd1, 2'd0, 16'hFFF0); wait_done(res, err, ec, st);
    start_op(3'd4, 2'd1, 2'd0, 16'd200); wait_done(res, err, ec, st);
    chk("addk_result", {16'd0, res}, 32'h00B8);
    chk("addk_ecycles", ec, 200);

    // SUBK count 0: upper data bits must not matter
    start_op(3'd5, 2'd1, 2'd0, 16'hAB00); wait_done(res, err, ec, st);
    chk("subk0_result", {16'd0, res}, 32'h00B8);
    chk("subk0_ecycles", ec, 0);
    chk("subk0_latency", st, 1);
    chk("subk0_error", {31'd0, err}, 32'd0);

    // COPY R3<-R1 with a request held while busy, then CLEAR R1 back-to-back
    start_op(3'd2, 2'd1, 2'd0, 16'hBEEF); wait_done(res, err, ec, st);
    start_op(3'd6, 2'd3, 2'd1, 16'h0000);
    ReqValid = 1'b1; ReqOp = 3'd2; ReqReg = 2'd0; ReqData = 16'hDEAD;
    @(posedge Clock); #1;
    chk("busy_ready", {31'd0, ReqReady}, 32'd0);
    @(posedge Clock); #1;
    chk("copy_done", {31'd0, Done}, 32'd1);
    chk("copy_result", {16'd0, Result}, 32'hBEEF);
    start_op(3'd3, 2'd1, 2'd0, 16'h0000);
    wait_done(res, err, ec, st);
    chk("copy_R3", {16'd0, bank[3]}, 32'hBEEF);
    chk("clear_R1", {16'd0, bank[1]}, 32'h0000);
    chk("busy_R0", {16'd0, bank[0]}, 32'hFFFF);

    // Reserved op on R2 (holds 0x1234)
    start_op(3'd7, 2'd2, 2'd0, 16'hFFFF); wait_done(res, err, ec, st);
    chk("rsvd_error", {31'd0, err}, 32'd1);
    chk("rsvd_ecycles", ec, 0);
    chk("rsvd_result", {16'd0, res}, 32'h1234);

    // Randomized operations, with gaps, back-to-back issue and busy requests
    for (int t = 0; t < 60; t++) begin
      rop = 3'($urandom_range(0, 7));
      rd  = 16'($urandom);
      if (rop == 3'd4 || rop == 3'd5) rd[7:0] = 8'($urandom_range(0, 12));
      repeat ($urandom_range(0, 2)) begin @(posedge Clock); #1; end
      start_op(rop, 2'($urandom), 2'($urandom), rd);
      if ($urandom_range(0, 3) == 0) begin
        ReqValid = 1'b1; ReqOp = 3'($urandom); ReqReg = 2'($urandom); ReqData = 16'($urandom);
        @(posedge Clock); #1;
        ReqValid = 1'b0;
      end
      wait_done(res, err, ec, st);
    end

    // Reset in WRITE cycle 5 of ADDK 10 from 0, with a request in the reset cycle
    start_op(3'd3, 2'd1, 2'd0, 16'h0000); wait_done(res, err, ec, st);
    start_op(3'd4, 2'd1, 2'd0, 16'd10);
    repeat (4) begin @(posedge Clock); #1; end
    chk("mid_E", {28'd0, E}, 32'h2);
    Reset = 1'b1; ReqValid = 1'b1; ReqOp = 3'd2; ReqReg = 2'd1; ReqData = 16'hDEAD;
    @(posedge Clock); #1;
    Reset = 1'b0; ReqValid = 1'b0;
    chk("rstw_E", {28'd0, E}, 32'd0);
    chk("rstw_ready", {31'd0, ReqReady}, 32'd1);
    chk("rstw_done", {31'd0, Done}, 32'd0);
    @(posedge Clock); #1;
    chk("rstw_R1", {16'd0, bank[1]}, 32'd5);
    chk("rstw_done2", {31'd0, Done}, 32'd0);
    repeat (3) begin @(posedge Clock); #1; end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
